stopwatch_input_cond: RTL and testbench

Input-conditioning stage that sits directly upstream of the stopwatch controller/display block. It turns raw board inputs and the 100 MHz board clock into clean, single-clock-domain controls:
- debounced one-cycle pulses for the reset (R) and pause (P) buttons;
- synchronized mode (`sel`) and preload (`load`) switches;
- the 100 Hz count-enable tick and the display-scan tick.

The downstream block uses these ticks as clock enables, so no derived clocks are needed.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/stopwatch_input_cond.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_input_cond.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input-conditioning slice.
//
// Contents:
//   CLK_HZ_DEF    default board clock frequency (Hz)
//   CNT_HZ_DEF    default count-tick rate (Hz), 0.01 s resolution
//   SCAN_HZ_DEF   default display-scan tick rate (Hz), one digit per tick
//   DB_CYCLES_DEF default number of consecutive stable cycles to accept a button change
//   div_w(n)      bit width needed for a counter whose terminal value is n

package stopwatch_pkg;

    localparam int unsigned CLK_HZ_DEF    = 100_000_000;
    localparam int unsigned CNT_HZ_DEF    = 100;
    localparam int unsigned SCAN_HZ_DEF   = 400;
    localparam int unsigned DB_CYCLES_DEF = 1_000_000;

    // Bits needed to hold every value 0..n; never less than one bit.
    function automatic int unsigned div_w(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, stable state
// and a registered one-cycle pulse on every accepted press (stable 0 -> 1).
//
// Ports:
//   clk     board clock
//   rst_n   asynchronous active-low reset; clears all state
//   btn     raw asynchronous button, active-high
//   rise_d  next-state of pulse: high in the cycle before pulse asserts
//   pulse   one-cycle registered press pulse

module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise_d,
    output logic pulse
);

    localparam int unsigned   DW       = div_w(DB_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          stable_d;
    logic          stable_prev_q;
    logic          pulse_q;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;

    // A change is accepted only after DB_CYCLES consecutive samples that
    // disagree with the current stable state; any agreeing sample restarts it.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (sync_q[1] == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_MAX) begin
            stable_d = ~stable_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Rising edge of the stable state; release produces nothing.
    assign rise_d = stable_q & ~stable_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            dcnt_q        <= '0;
            pulse_q       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], btn};
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            dcnt_q        <= dcnt_d;
            pulse_q       <= rise_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_input_cond.sv
// Input-conditioning stage in front of the stopwatch controller/display.
// Turns raw board inputs into clean single-clock-domain controls:
// debounced press pulses, synchronized switches, and clock-enable ticks.
//
// Ports:
//   clk        board clock; the only clock
//   rst_n      asynchronous active-low reset
//   btn_r      raw reset button (active-high, asynchronous)
//   btn_p      raw pause/start button (active-high, asynchronous)
//   sw_sel     raw mode switches
//   sw_load    raw preload switches (two BCD digits)
//   r_pulse    one-cycle pulse per debounced R press
//   p_pulse    one-cycle pulse per debounced P press (suppressed when R pulses too)
//   sel        synchronized mode
//   load       synchronized preload
//   sel_chg    one-cycle pulse when sel changes value
//   cnt_tick   one-cycle enable at CNT_HZ, restarted by r_pulse/p_pulse/sel_chg
//   scan_tick  one-cycle enable at SCAN_HZ, free-running

module stopwatch_input_cond
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned CNT_HZ    = CNT_HZ_DEF,
    parameter int unsigned SCAN_HZ   = SCAN_HZ_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_r,
    input  logic       btn_p,
    input  logic [1:0] sw_sel,
    input  logic [7:0] sw_load,
    output logic       r_pulse,
    output logic       p_pulse,
    output logic [1:0] sel,
    output logic [7:0] load,
    output logic       sel_chg,
    output logic       cnt_tick,
    output logic       scan_tick
);

    localparam int unsigned CNT_DIV  = CLK_HZ / CNT_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W    = div_w(CNT_DIV - 1);
    localparam int unsigned SCAN_W   = div_w(SCAN_DIV - 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CNT_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    if ((CLK_HZ % CNT_HZ) != 0 || CNT_DIV < 2) begin : g_bad_cnt_div
        $error("CLK_HZ/CNT_HZ must be an integer >= 2");
    end
    if ((CLK_HZ % SCAN_HZ) != 0 || SCAN_DIV < 2) begin : g_bad_scan_div
        $error("CLK_HZ/SCAN_HZ must be an integer >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("DB_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Buttons
    // ------------------------------------------------------------------
    logic r_rise_d;
    logic p_rise_d;
    logic r_pls;
    logic p_pls;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_r),
        .rise_d (r_rise_d),
        .pulse  (r_pls)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_p (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_p),
        .rise_d (p_rise_d),
        .pulse  (p_pls)
    );

    // R wins a same-cycle collision so a reset is never mistaken for a start.
    assign r_pulse = r_pls;
    assign p_pulse = p_pls & ~r_pls;

    // ------------------------------------------------------------------
    // Switches: synchronized only, no debounce
    // ------------------------------------------------------------------
    logic [1:0] sel_s1_q;
    logic [1:0] sel_q;
    logic [1:0] sel_prev_q;
    logic [7:0] load_s1_q;
    logic [7:0] load_q;
    logic       sel_chg_q;
    logic       sel_chg_d;

    assign sel_chg_d = (sel_q != sel_prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1_q   <= '0;
            sel_q      <= '0;
            sel_prev_q <= '0;
            load_s1_q  <= '0;
            load_q     <= '0;
            sel_chg_q  <= 1'b0;
        end else begin
            sel_s1_q   <= sw_sel;
            sel_q      <= sel_s1_q;
            sel_prev_q <= sel_q;
            load_s1_q  <= sw_load;
            load_q     <= load_s1_q;
            sel_chg_q  <= sel_chg_d;
        end
    end

    assign sel     = sel_q;
    assign load    = load_q;
    assign sel_chg = sel_chg_q;

    // ------------------------------------------------------------------
    // Prescalers
    // ------------------------------------------------------------------
    // Restart is taken from the pulses' next-state so the counter clears on
    // the same edge the pulse appears; the next tick is then one full period
    // after the pulse cycle. Restart beats wrap.
    logic              restart;
    logic [CNT_W-1:0]  pcnt_q;
    logic [CNT_W-1:0]  pcnt_d;
    logic              cnt_tick_q;
    logic [SCAN_W-1:0] scnt_q;
    logic [SCAN_W-1:0] scnt_d;
    logic              scan_tick_q;

    assign restart = r_rise_d | p_rise_d | sel_chg_d;

    always_comb begin
        pcnt_d = pcnt_q + CNT_W'(1);
        if (restart || pcnt_q == CNT_MAX) begin
            pcnt_d = '0;
        end
        scnt_d = scnt_q + SCAN_W'(1);
        if (scnt_q == SCAN_MAX) begin
            scnt_d = '0;
        end
    end

    // Ticks are registered off the terminal count, so the first tick after
    // reset lands exactly one divisor period after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            cnt_tick_q  <= 1'b0;
            scnt_q      <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            cnt_tick_q  <= (pcnt_q == CNT_MAX);
            scnt_q      <= scnt_d;
            scan_tick_q <= (scnt_q == SCAN_MAX);
        end
    end

    assign cnt_tick  = cnt_tick_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_stopwatch_input_cond.sv
// Self-checking bench for stopwatch_input_cond with small sim parameters.
// Cycle k of an epoch is the clock period after the k-th rising edge,
// counting the edge just before reset release as edge 0.

module tb_stopwatch_input_cond;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned CNT_HZ  = 100;
    localparam int unsigned SCAN_HZ = 250;
    localparam int unsigned DB      = 5;
    localparam int PC   = CLK_HZ / CNT_HZ;
    localparam int PS   = CLK_HZ / SCAN_HZ;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_r = 1'b0;
    logic       btn_p = 1'b0;
    logic [1:0] sw_sel = '0;
    logic [7:0] sw_load = '0;
    logic       r_pulse, p_pulse, sel_chg, cnt_tick, scan_tick;
    logic [1:0] sel;
    logic [7:0] load;

    int total = 0;
    int bad = 0;

    stopwatch_input_cond #(
        .CLK_HZ    (CLK_HZ),
        .CNT_HZ    (CNT_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_r     (btn_r),
        .btn_p     (btn_p),
        .sw_sel    (sw_sel),
        .sw_load   (sw_load),
        .r_pulse   (r_pulse),
        .p_pulse   (p_pulse),
        .sel       (sel),
        .load      (load),
        .sel_chg   (sel_chg),
        .cnt_tick  (cnt_tick),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    // Raw input as sampled at edge e, model stable states, and DUT history.
    bit         raw_r [MAXC];
    bit         raw_p [MAXC];
    logic [1:0] raw_sel [MAXC];
    logic [7:0] raw_load [MAXC];
    bit         st_r [MAXC];
    bit         st_p [MAXC];
    logic [1:0] m_sel [MAXC];
    bit         h_r [MAXC];
    bit         h_p [MAXC];
    bit         h_cnt [MAXC];
    bit         h_scan [MAXC];
    bit         h_chg [MAXC];
    logic [1:0] h_sel [MAXC];

    int cyc = 0;
    int anchor = 0;
    bit e_r, e_p, e_chg, e_cnt, e_scan;
    logic [7:0] e_load;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    // Two-flop synchronizer: the value seen in cycle c was sampled at edge c-1.
    function automatic bit sync_at(input bit is_p, input int c);
        if (c < 2) return 1'b0;
        return is_p ? raw_p[c-1] : raw_r[c-1];
    endfunction

    // Stable state flips at edge c only if the DB synced samples before it all disagree.
    function automatic bit stable_at(input bit is_p, input int c);
        bit prev;
        bit flip;
        if (c == 0) return 1'b0;
        prev = is_p ? st_p[c-1] : st_r[c-1];
        flip = 1'b1;
        for (int k = 1; k <= int'(DB); k++) begin
            if (c - k < 0 || sync_at(is_p, c - k) == prev) flip = 1'b0;
        end
        return flip ? !prev : prev;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            anchor = 0;
            chk("rst_r_pulse", 32'(r_pulse), 0);
            chk("rst_p_pulse", 32'(p_pulse), 0);
            chk("rst_sel", 32'(sel), 0);
            chk("rst_load", 32'(load), 0);
            chk("rst_sel_chg", 32'(sel_chg), 0);
            chk("rst_cnt_tick", 32'(cnt_tick), 0);
            chk("rst_scan_tick", 32'(scan_tick), 0);
        end else if (cyc < MAXC - 1) begin
            st_r[cyc] = stable_at(1'b0, cyc);
            st_p[cyc] = stable_at(1'b1, cyc);
            e_r = (cyc >= 2) && st_r[cyc-1] && !st_r[cyc-2];
            e_p = (cyc >= 2) && st_p[cyc-1] && !st_p[cyc-2];
            m_sel[cyc] = (cyc >= 2) ? raw_sel[cyc-1] : 2'b00;
            e_load = (cyc >= 2) ? raw_load[cyc-1] : 8'h00;
            e_chg = (cyc >= 2) && (m_sel[cyc-1] != m_sel[cyc-2]);
            e_cnt = (cyc > anchor) && ((cyc - anchor) % PC == 0);
            e_scan = (cyc > 0) && (cyc % PS == 0);
            if (e_r || e_p || e_chg) anchor = cyc;

            chk("r_pulse", 32'(r_pulse), 32'(e_r));
            chk("p_pulse", 32'(p_pulse), 32'(e_p && !e_r));
            chk("sel", 32'(sel), 32'(m_sel[cyc]));
            chk("load", 32'(load), 32'(e_load));
            chk("sel_chg", 32'(sel_chg), 32'(e_chg));
            chk("cnt_tick", 32'(cnt_tick), 32'(e_cnt));
            chk("scan_tick", 32'(scan_tick), 32'(e_scan));

            h_r[cyc] = r_pulse;
            h_p[cyc] = p_pulse;
            h_cnt[cyc] = cnt_tick;
            h_scan[cyc] = scan_tick;
            h_chg[cyc] = sel_chg;
            h_sel[cyc] = sel;

            raw_r[cyc+1] = btn_r;
            raw_p[cyc+1] = btn_p;
            raw_sel[cyc+1] = sw_sel;
            raw_load[cyc+1] = sw_load;
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset mid-cycle, then release just after "edge 0" of a fresh epoch.
    task automatic start_epoch(input bit rand_init);
        @(posedge clk);
        #2 rst_n = 1'b0;
        btn_r = 1'b0;
        btn_p = 1'b0;
        sw_sel = '0;
        sw_load = '0;
        if (rand_init) begin
            btn_r = 1'($urandom_range(0, 1));
            btn_p = 1'($urandom_range(0, 1));
            sw_sel = 2'($urandom);
            sw_load = 8'($urandom);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int hold_r;
        int hold_p;
        int n;
        #1 rst_n = 1'b0;

        // Idle after reset: tick phases.
        start_epoch(1'b0);
        step(35);
        chk("lit_cnt_9", 32'(h_cnt[9]), 0);
        chk("lit_cnt_10", 32'(h_cnt[10]), 1);
        chk("lit_cnt_20", 32'(h_cnt[20]), 1);
        chk("lit_cnt_30", 32'(h_cnt[30]), 1);
        chk("lit_scan_4", 32'(h_scan[4]), 1);
        chk("lit_scan_12", 32'(h_scan[12]), 1);

        // Clean P press held 50 cycles, then released.
        start_epoch(1'b0);
        btn_p = 1'b1;
        step(50);
        btn_p = 1'b0;
        step(20);
        chk("lit_p_7", 32'(h_p[7]), 0);
        chk("lit_p_8", 32'(h_p[8]), 1);
        n = 0;
        for (int c = 0; c < 70; c++) n += int'(h_p[c]);
        chk("lit_p_once", n, 1);

        // Bouncy R for 30 cycles, settling high at edge 30.
        start_epoch(1'b0);
        for (int i = 0; i < 10; i++) begin
            btn_r = (i % 2 == 0);
            step(3);
        end
        btn_r = 1'b1;
        step(20);
        chk("lit_r_38", 32'(h_r[38]), 1);
        n = 0;
        for (int c = 0; c < 50; c++) n += int'(h_r[c]);
        chk("lit_r_once", n, 1);

        // R and P on the same edge: R wins.
        start_epoch(1'b0);
        btn_r = 1'b1;
        btn_p = 1'b1;
        step(20);
        chk("lit_both_r_8", 32'(h_r[8]), 1);
        n = 0;
        for (int c = 0; c < 20; c++) n += int'(h_p[c]);
        chk("lit_both_no_p", n, 0);

        // P pulse at cycle 23 restarts the count prescaler.
        start_epoch(1'b0);
        step(15);
        btn_p = 1'b1;
        step(25);
        chk("lit_rs_p_23", 32'(h_p[23]), 1);
        chk("lit_rs_cnt_20", 32'(h_cnt[20]), 1);
        chk("lit_rs_cnt_30", 32'(h_cnt[30]), 0);
        chk("lit_rs_cnt_33", 32'(h_cnt[33]), 1);
        chk("lit_rs_scan_24", 32'(h_scan[24]), 1);

        // Switch change, then async reset in the middle of an R debounce.
        start_epoch(1'b0);
        sw_sel = 2'b10;
        step(6);
        chk("lit_sel_1", 32'(h_sel[1]), 0);
        chk("lit_sel_2", 32'(h_sel[2]), 2);
        chk("lit_chg_2", 32'(h_chg[2]), 0);
        chk("lit_chg_3", 32'(h_chg[3]), 1);
        chk("lit_chg_4", 32'(h_chg[4]), 0);
        btn_r = 1'b1;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_clear", 32'({r_pulse, p_pulse, sel, load, sel_chg, cnt_tick, scan_tick}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(15);
        chk("lit_rel_r_7", 32'(h_r[7]), 0);
        chk("lit_rel_r_8", 32'(h_r[8]), 1);

        // Randomized epochs against the model.
        for (int ep = 0; ep < 4; ep++) begin
            start_epoch(ep[0]);
            hold_r = 0;
            hold_p = 0;
            for (int i = 0; i < 400; i++) begin
                if (hold_r <= 0) begin
                    btn_r = 1'($urandom_range(0, 1));
                    hold_r = $urandom_range(1, 12);
                end
                if (hold_p <= 0) begin
                    btn_p = 1'($urandom_range(0, 1));
                    hold_p = $urandom_range(1, 12);
                end
                if ($urandom_range(0, 29) == 0) begin
                    btn_r = 1'b1;
                    btn_p = 1'b1;
                    hold_r = 8;
                    hold_p = 8;
                end
                if ($urandom_range(0, 39) == 0) sw_sel = 2'($urandom);
                if ($urandom_range(0, 9) == 0) sw_load = 8'($urandom);
                hold_r--;
                hold_p--;
                step(1);
            end
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
